// File: rtl/iter_alu_if.sv
// Handshake bundle for iter_alu: operand side (in_*) and result side (out_*, flags).
// master = producer/consumer around the ALU, slave = the ALU itself.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, op, in_a, in_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, carry, ovf
  );

  modport slave (
    input  in_valid, op, in_a, in_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, carry, ovf
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: add/sub/logic in one cycle, shifts iterate one bit per clock.
// Result and flags are registered and held in DONE until the consumer accepts them.
module iter_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  iter_alu_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_SRA = 3'b000, OP_SRL = 3'b001, OP_SUB = 3'b010, OP_ADD = 3'b011,
    OP_SLL = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;
  logic [SHW-1:0]   r_count;

  op_t              w_in_op;
  op_t              w_sop;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_shifted;
  logic             w_sout;
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_c;
  logic             w_alu_v;

  always_comb begin
    w_in_op    = op_t'(bus.op);
    w_is_shift = (w_in_op == OP_SRA) || (w_in_op == OP_SRL) || (w_in_op == OP_SLL);

    // One shifter serves both the first step (from in_a) and the iterative steps (from r_acc).
    w_src = (r_state == IDLE) ? bus.in_a : r_acc;
    w_sop = (r_state == IDLE) ? w_in_op : r_op;
    case (w_sop)
      OP_SLL: begin
        w_shifted = {w_src[WIDTH-2:0], 1'b0};
        w_sout    = w_src[WIDTH-1];
      end
      OP_SRA: begin
        w_shifted = {w_src[WIDTH-1], w_src[WIDTH-1:1]};
        w_sout    = w_src[0];
      end
      default: begin
        w_shifted = {1'b0, w_src[WIDTH-1:1]};
        w_sout    = w_src[0];
      end
    endcase

    w_sub = (w_in_op == OP_SUB);
    w_bx  = w_sub ? ~bus.in_b : bus.in_b;
    w_sum = {1'b0, bus.in_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};

    w_alu   = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (w_in_op)
      OP_ADD, OP_SUB: begin
        w_alu   = w_sum[WIDTH-1:0];
        w_alu_c = w_sub ? ~w_sum[WIDTH] : w_sum[WIDTH];
        w_alu_v = (bus.in_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_AND:  w_alu = bus.in_a & bus.in_b;
      OP_OR:   w_alu = bus.in_a | bus.in_b;
      OP_XOR:  w_alu = bus.in_a ^ bus.in_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= OP_SRA;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op <= w_in_op;
            if (!w_is_shift) begin
              r_acc   <= w_alu;
              r_carry <= w_alu_c;
              r_ovf   <= w_alu_v;
              r_state <= DONE;
            end else if (bus.shamt == '0) begin
              r_acc   <= bus.in_a;
              r_carry <= 1'b0;
              r_ovf   <= 1'b0;
              r_state <= DONE;
            end else begin
              r_acc   <= w_shifted;
              r_carry <= w_sout;
              r_ovf   <= 1'b0;
              r_count <= bus.shamt - SHW'(1);
              r_state <= (bus.shamt == SHW'(1)) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          r_acc   <= w_shifted;
          r_carry <= w_sout;
          r_count <= r_count - SHW'(1);
          if (r_count == SHW'(1)) r_state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_acc;
  assign bus.zero      = (r_acc == '0);
  assign bus.carry     = r_carry;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (WIDTH=8): table of ops with hand-computed results,
// plus hold-under-backpressure and mid-shift reset sequences.
module tb_iter_alu;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  iter_alu_if #(.WIDTH(8)) bus ();
  iter_alu #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sh;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    int lat;
    chk($sformatf("v%0d in_ready_idle", idx), {31'b0, bus.in_ready}, 32'd1);
    bus.op = t.op; bus.in_a = t.a; bus.in_b = t.b; bus.shamt = t.sh;
    bus.in_valid = 1'b1;
    tick();
    lat = 1;
    // Busy: scramble the inputs with in_valid held high; they must be ignored.
    while (!bus.out_valid && lat < 40) begin
      chk($sformatf("v%0d in_ready_busy", idx), {31'b0, bus.in_ready}, 32'd0);
      bus.op = 3'($urandom); bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      bus.shamt = 3'($urandom);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d latency", idx), lat, t.lat);
    chk($sformatf("v%0d result", idx), {24'b0, bus.result}, {24'b0, t.res});
    chk($sformatf("v%0d flags_czv", idx), {29'b0, bus.carry, bus.zero, bus.ovf},
        {29'b0, t.c, t.z, t.v});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_drop", idx), {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    //          op      a      b      sh    res    c     v     z    lat
    vecs[0]  = '{3'b011, 8'h7F, 8'h01, 3'd5, 8'h80, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'b010, 8'h00, 8'h01, 3'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'b010, 8'h05, 8'h05, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{3'b000, 8'h90, 8'hA5, 3'd3, 8'hF2, 1'b0, 1'b0, 1'b0, 3};
    vecs[4]  = '{3'b100, 8'h83, 8'h3C, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0, 7};
    vecs[5]  = '{3'b001, 8'h81, 8'hFF, 3'd0, 8'h81, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'b011, 8'hFF, 8'h01, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1};
    vecs[7]  = '{3'b010, 8'h80, 8'h01, 3'd3, 8'h7F, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{3'b101, 8'hF0, 8'h3C, 3'd4, 8'h30, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b110, 8'hF0, 8'h0C, 3'd6, 8'hFC, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'b111, 8'hAA, 8'hFF, 3'd2, 8'h55, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{3'b111, 8'h5A, 8'h5A, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[12] = '{3'b001, 8'h81, 8'h00, 3'd1, 8'h40, 1'b1, 1'b0, 1'b0, 1};
    vecs[13] = '{3'b000, 8'h81, 8'h11, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 7};
    vecs[14] = '{3'b100, 8'h01, 8'h22, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{3'b001, 8'h80, 8'h33, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, 7};
    vecs[16] = '{3'b000, 8'h7F, 8'h44, 3'd2, 8'h1F, 1'b1, 1'b0, 1'b0, 2};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'b0; bus.in_a = 8'h0; bus.in_b = 8'h0; bus.shamt = 3'd0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_result", {24'b0, bus.result}, 32'd0);
    chk("rst_flags_czv", {29'b0, bus.carry, bus.zero, bus.ovf}, {29'b0, 3'b010});
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Backpressure: ADD result held while new operands wait on in_valid.
    bus.op = 3'b011; bus.in_a = 8'h7F; bus.in_b = 8'h01; bus.in_valid = 1'b1;
    tick();
    bus.in_a = 8'h01; bus.in_b = 8'h02;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d out_valid", k), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("hold%0d in_ready", k), {31'b0, bus.in_ready}, 32'd0);
      chk($sformatf("hold%0d result", k), {24'b0, bus.result}, 32'h80);
      chk($sformatf("hold%0d flags_czv", k), {29'b0, bus.carry, bus.zero, bus.ovf},
          {29'b0, 3'b001});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hold_release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("hold_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("next_op_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("next_op_result", {24'b0, bus.result}, 32'h03);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset three edges into SRL 81 shamt=7.
    bus.op = 3'b001; bus.in_a = 8'h81; bus.in_b = 8'h00; bus.shamt = 3'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("midshift_busy", {31'b0, bus.in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("async_rst_result", {24'b0, bus.result}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst%0d out_valid", k), {31'b0, bus.out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
